// File: rtl/digit_serial_loop_pkg.sv
// Shared definitions for the digit-serial ALU loop.
// Holds the command and FSM state enums and the default word geometry.
package digit_serial_loop_pkg;

  localparam int DIGIT_W_DEF    = 4;
  localparam int NUM_DIGITS_DEF = 8;

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_SUB   = 3'd1,
    CMD_AND   = 3'd2,
    CMD_OR    = 3'd3,
    CMD_XOR   = 3'd4,
    CMD_LSHFT = 3'd5,
    CMD_RSHFT = 3'd6
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_serial_loop_if.sv
// Request/response bundle of digit_serial_loop.
//   master : drives start, cmd, inc_mode, last_idx, carry_in, word1, word2
//            and observes ready, busy, done, result, carry_out
//   slave  : the loop itself (mirror image of master)
interface digit_serial_loop_if
  import digit_serial_loop_pkg::*;
#(
  parameter int DIGIT_W    = DIGIT_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) ();

  localparam int WORD_W = DIGIT_W * NUM_DIGITS;

  logic              start;
  logic              ready;
  alu_cmd_e          cmd;
  logic              inc_mode;
  logic [IDX_W-1:0]  last_idx;
  logic              carry_in;
  logic [WORD_W-1:0] word1;
  logic [WORD_W-1:0] word2;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] result;
  logic              carry_out;

  modport master (
    output start, cmd, inc_mode, last_idx, carry_in, word1, word2,
    input  ready, busy, done, result, carry_out
  );

  modport slave (
    input  start, cmd, inc_mode, last_idx, carry_in, word1, word2,
    output ready, busy, done, result, carry_out
  );

endinterface

// File: rtl/digit_alu.sv
// Combinational single-digit ALU used by digit_serial_loop.
//   cmd   : operation selector
//   d1,d2 : operand digits (d2 is also the shift source)
//   c_in  : incoming carry / shift fill bit
//   d_out : result digit
//   c_out : outgoing carry / borrow-free flag / shifted-out bit
module digit_alu
  import digit_serial_loop_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  alu_cmd_e           cmd,
  input  logic [DIGIT_W-1:0] d1,
  input  logic [DIGIT_W-1:0] d2,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] d_out,
  output logic               c_out
);

  logic [DIGIT_W:0] sum;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // assignment in some branch would otherwise infer a latch.
    sum   = '0;
    d_out = '0;
    c_out = 1'b0;
    unique case (cmd)
      CMD_ADD: begin
        sum   = {1'b0, d1} + {1'b0, d2} + {{DIGIT_W{1'b0}}, c_in};
        d_out = sum[DIGIT_W-1:0];
        c_out = sum[DIGIT_W];
      end
      CMD_SUB: begin
        // Two's-complement subtract: carry out of 1 means no borrow.
        sum   = {1'b0, d1} + {1'b0, ~d2} + {{DIGIT_W{1'b0}}, c_in};
        d_out = sum[DIGIT_W-1:0];
        c_out = sum[DIGIT_W];
      end
      CMD_AND:   d_out = d1 & d2;
      CMD_OR:    d_out = d1 | d2;
      CMD_XOR:   d_out = d1 ^ d2;
      CMD_LSHFT: begin
        d_out = {d2[DIGIT_W-2:0], c_in};
        c_out = d2[DIGIT_W-1];
      end
      CMD_RSHFT: begin
        d_out = {c_in, d2[DIGIT_W-1:1]};
        c_out = d2[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/digit_serial_loop.sv
// Digit-serial ALU: processes one DIGIT_W-bit digit per clock over digits
// 0..last_idx (RSHFT walks downward), carrying between digits in a register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side), see digit_serial_loop_if
module digit_serial_loop
  import digit_serial_loop_pkg::*;
#(
  parameter int DIGIT_W    = DIGIT_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  digit_serial_loop_if.slave bus
);

  localparam int               WORD_W  = DIGIT_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_DIGITS - 1);

  // Operation captured at accept; later input changes cannot disturb a run.
  typedef struct packed {
    alu_cmd_e          cmd;
    logic              inc;
    logic [IDX_W-1:0]  last;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
  } op_t;

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;

  logic              accept;
  logic              run_end;
  logic [IDX_W-1:0]  last_clamped;
  logic [DIGIT_W-1:0] d1, d2, alu_d;
  logic              alu_c;

  assign accept       = bus.start && (state_q != ST_RUN);
  assign last_clamped = ({1'b0, bus.last_idx} >= (IDX_W+1)'(NUM_DIGITS)) ? MAX_IDX : bus.last_idx;

  assign d1 = op_q.w1[int'(idx_q)*DIGIT_W +: DIGIT_W];
  assign d2 = op_q.w2[int'(idx_q)*DIGIT_W +: DIGIT_W];

  digit_alu #(.DIGIT_W(DIGIT_W)) u_alu (
    .cmd   (op_q.cmd),
    .d1    (d1),
    .d2    (d2),
    .c_in  (carry_q),
    .d_out (alu_d),
    .c_out (alu_c)
  );

  // Last digit of this run: natural end of the walk, or an increment whose
  // carry has died out above digit 0.
  always_comb begin
    run_end = (op_q.cmd == CMD_RSHFT) ? (idx_q == '0) : (idx_q == op_q.last);
    if (op_q.inc && (op_q.cmd == CMD_ADD) && !alu_c && (idx_q != '0)) run_end = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (run_end) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, preload on accept, one digit per RUN cycle.
  always_comb begin
    op_d     = op_q;
    idx_d    = idx_q;
    result_d = result_q;
    carry_d  = carry_q;
    if (accept) begin
      op_d     = '{cmd: bus.cmd, inc: bus.inc_mode, last: last_clamped,
                   w1: bus.word1, w2: bus.word2};
      idx_d    = (bus.cmd == CMD_RSHFT) ? last_clamped : '0;
      result_d = (bus.cmd == CMD_LSHFT || bus.cmd == CMD_RSHFT) ? bus.word2 : bus.word1;
      carry_d  = (bus.cmd == CMD_SUB) ? ~bus.carry_in : bus.carry_in;
    end else if (state_q == ST_RUN) begin
      result_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = alu_d;
      carry_d = alu_c;
      if (!run_end) idx_d = (op_q.cmd == CMD_RSHFT) ? idx_q - 1'b1 : idx_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // NOTE: the operand register has no reset: it is always written at accept
  // before anything reads it, so resetting it would only cost reset routing.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  // Outputs.
  always_comb begin
    bus.ready     = (state_q != ST_RUN);
    bus.busy      = (state_q == ST_RUN);
    bus.done      = (state_q == ST_DONE);
    bus.result    = result_q;
    bus.carry_out = carry_q;
  end

endmodule

// File: doc/digit_serial_loop.md
DIGIT_SERIAL_LOOP -- requirements
Module: digit_serial_loop

Interface
REQ-001 Parameters SHALL be:
- DIGIT_W, default 4: digit width in bits.
- NUM_DIGITS, default 8: digits per word.
- IDX_W, default $clog2(NUM_DIGITS): width of the digit index.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: operation request.
- ready, out, 1: request can be accepted.
- cmd, in, AluCmd: ADD, SUB, AND, OR, XOR, LSHFT, RSHFT.
- inc_mode, in, 1: early-terminating increment (ADD only).
- last_idx, in, IDX_W: index of the most significant active digit.
- carry_in, in, 1: initial carry, or shift fill bit.
- word1, in, DIGIT_W*NUM_DIGITS: operand A.
- word2, in, DIGIT_W*NUM_DIGITS: operand B, and the shift source.
- busy, out, 1: an operation is in progress.
- done, out, 1: one-cycle completion pulse.
- result, out, DIGIT_W*NUM_DIGITS: operation result.
- carry_out, out, 1: final carry, borrow or shifted-out bit.

Function
REQ-003 The block SHALL have three states: IDLE, RUN and DONE. DONE SHALL last exactly one cycle and then go to IDLE unless a new start is accepted.
REQ-004 ready SHALL be high in IDLE and DONE and low in RUN; busy SHALL equal (state==RUN).
REQ-005 start SHALL be accepted on an edge where start && ready. start while RUN SHALL be ignored, with no queueing.
REQ-006 On acceptance the block SHALL register cmd, inc_mode, last_idx, word1 and word2, so later input changes have no effect.
REQ-007 On acceptance the result register SHALL be preloaded with word2 for LSHFT/RSHFT and with word1 otherwise; digits above last_idx therefore pass through unchanged.
REQ-008 On acceptance the carry register SHALL be loaded with ~carry_in for SUB and with carry_in otherwise.
REQ-009 Digit order SHALL be:
- RSHFT: digit last_idx down to digit 0.
- All other commands: digit 0 up to digit last_idx.
REQ-010 Exactly one digit SHALL be processed per RUN cycle: result[idx] and the carry register are both written on that edge.
REQ-011 Per-digit operations SHALL be:
- ADD: d1+d2+c; carry = bit DIGIT_W of the sum.
- SUB: d1+~d2+c; carry = bit DIGIT_W of the sum.
- AND/OR/XOR: bitwise d1,d2; carry held at 0.
- LSHFT: {d2[DIGIT_W-2:0],c}; carry = d2[DIGIT_W-1].
- RSHFT: {c,d2[DIGIT_W-1:1]}; carry = d2[0].
REQ-012 Without inc_mode, RUN SHALL last last_idx+1 cycles and done SHALL assert in the cycle after the last digit edge. Latency from the accept edge to done high SHALL be last_idx+2 edges.
REQ-013 With inc_mode and cmd==ADD, RUN SHALL terminate after the current digit when the new carry is 0 and idx>0, or when idx==last_idx. inc_mode with any other cmd SHALL be ignored.
REQ-014 carry_out SHALL be the final carry register value:
- For SUB, 1 means no borrow.
- For logic ops, carry_out SHALL be 0.
REQ-015 result and carry_out SHALL be stable from done until the next accept.
REQ-016 last_idx==0 SHALL yield one RUN cycle.
REQ-017 last_idx>=NUM_DIGITS SHALL be clamped to NUM_DIGITS-1 at acceptance.
REQ-018 start held through DONE SHALL be accepted in DONE, giving back-to-back operations with no IDLE cycle.

Reset
REQ-019 rst_n low SHALL force, asynchronously:
- state = IDLE;
- result = 0, carry_out = 0, done = 0, busy = 0;
- ready = 1;
- the index counter = 0.
REQ-020 Reset during RUN SHALL abort the operation with no done pulse; the first accept after rst_n rises SHALL behave as from power-up.

Structure
REQ-021 The AluCmd enum and the state enum SHALL live in the shared ALU package; DIGIT_W and NUM_DIGITS defaults SHALL be package constants.
REQ-022 The per-digit operation SHALL be a combinational sub-module, digit_alu, parametrised by DIGIT_W. Counter, FSM and result register SHALL stay in digit_serial_loop.

Verification
REQ-023 ADD, word1=0x0EFF_FFFF, word2=1, last_idx=7, carry_in=0 -> result=0x0F00_0000, carry_out=0, done 9 edges after accept.
REQ-024 ADD with inc_mode, word1=0x0000_00FF, word2=1 -> result=0x0000_0100, busy for 3 cycles, done pulse.
REQ-025 SUB, 0x0000_0002 minus 0x0000_0003, carry_in=0 -> result=0xFFFF_FFFF, carry_out=0; SUB 5-3 -> 0x0000_0002, carry_out=1.
REQ-026 RSHFT word2=0x0600_0000, carry_in=0 -> 0x0300_0000. LSHFT word2=0x8000_0001, carry_in=1 -> 0x0000_0003, carry_out=1.
REQ-027 ADD, last_idx=3, word1=0x1234_FFFF, word2=1 -> result=0x1234_0000, carry_out=1.
REQ-028 Reset and parameter checks:
- rst_n pulsed in the 3rd RUN cycle -> IDLE, result 0, no done.
- DIGIT_W=8, NUM_DIGITS=4 instance: 0x00FF_FFFF+1 -> 0x0100_0000.
